// File: rtl/usr_shift_sequencer.sv
// Command-driven sequencer for a universal shift register: accepts CLEAR/LOAD/SHIFT commands
// over valid/ready, drives the register pins cycle by cycle, and reports the final contents.
module usr_shift_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_rot,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sr_se,
    output logic [WIDTH-1:0] sr_par,
    output logic             sr_left_in,
    output logic             sr_right_in,
    output logic             sr_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] OpClear = 2'b00;
    localparam logic [1:0] OpShl   = 2'b01;
    localparam logic [1:0] OpShr   = 2'b10;
    localparam logic [1:0] OpLoad  = 2'b11;

    localparam logic [1:0] SeHold  = 2'b00;
    localparam logic [1:0] SeLeft  = 2'b01;
    localparam logic [1:0] SeRight = 2'b10;
    localparam logic [1:0] SeLoad  = 2'b11;

    typedef enum logic [1:0] {StInit, StIdle, StExec, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q;
    logic               rot_q;
    logic               fill_q;
    logic [WIDTH-1:0]   data_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               cmd_hs;
    logic               cmd_is_shift;

    assign cmd_ready    = (state_q == StIdle);
    assign cmd_hs       = cmd_valid && cmd_ready;
    assign cmd_is_shift = (cmd_op == OpShl) || (cmd_op == OpShr);
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign result       = result_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_se       = SeHold;
        sr_par      = '0;
        sr_left_in  = 1'b0;
        sr_right_in = 1'b0;
        sr_clr      = 1'b0;

        unique case (state_q)
            StInit: begin
                sr_clr  = 1'b1;
                state_d = StIdle;
            end
            StIdle: begin
                if (cmd_hs) begin
                    // A zero-length shift skips EXEC so the register is never touched
                    if (cmd_is_shift && (cmd_cnt == '0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StExec;
                        cnt_d   = cmd_is_shift ? cmd_cnt : CNT_W'(1);
                    end
                end
            end
            StExec: begin
                unique case (op_q)
                    OpClear: sr_clr = 1'b1;
                    OpLoad: begin
                        sr_se  = SeLoad;
                        sr_par = data_q;
                    end
                    OpShl: begin
                        sr_se       = SeLeft;
                        sr_right_in = rot_q ? sr_q[WIDTH-1] : fill_q;
                    end
                    OpShr: begin
                        sr_se      = SeRight;
                        sr_left_in = rot_q ? sr_q[0] : fill_q;
                    end
                    default: ;
                endcase
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            op_q     <= '0;
            rot_q    <= 1'b0;
            fill_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == StDone);
            if (state_q == StDone) begin
                result_q <= sr_q;
            end
            if (cmd_hs) begin
                op_q   <= cmd_op;
                rot_q  <= cmd_rot;
                fill_q <= cmd_fill;
                data_q <= cmd_data;
            end
        end
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer paired with a behavioural 4-bit universal shift register;
// directed and random commands checked against an arithmetic reference model.
module tb_usr_shift_sequencer;

    localparam int W  = 4;
    localparam int CW = 3;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_SL  = 2'b01;
    localparam logic [1:0] OP_SR  = 2'b10;
    localparam logic [1:0] OP_LD  = 2'b11;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          cmd_rot = 1'b0;
    logic          cmd_fill = 1'b0;
    logic [W-1:0]  cmd_data = '0;
    logic [W-1:0]  sr_q;
    logic [1:0]    sr_se;
    logic [W-1:0]  sr_par;
    logic          sr_left_in;
    logic          sr_right_in;
    logic          sr_clr;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] model = '0;

    always #5 clk = ~clk;

    usr_shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_cnt     (cmd_cnt),
        .cmd_rot     (cmd_rot),
        .cmd_fill    (cmd_fill),
        .cmd_data    (cmd_data),
        .sr_q        (sr_q),
        .sr_se       (sr_se),
        .sr_par      (sr_par),
        .sr_left_in  (sr_left_in),
        .sr_right_in (sr_right_in),
        .sr_clr      (sr_clr),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    // Behavioural universal shift register
    logic [W-1:0] sr_reg;
    assign sr_q = sr_reg;
    always_ff @(posedge clk) begin
        if (sr_clr) sr_reg <= '0;
        else begin
            case (sr_se)
                2'b01:   sr_reg <= {sr_reg[W-2:0], sr_right_in};
                2'b10:   sr_reg <= {sr_left_in, sr_reg[W-1:1]};
                2'b11:   sr_reg <= sr_par;
                default: sr_reg <= sr_reg;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Final register value after a command, from the command's definition in plain arithmetic
    function automatic logic [W-1:0] ref_apply(input logic [W-1:0] v, input logic [1:0] op,
                                               input int n, input logic rot, input logic fill,
                                               input logic [W-1:0] d);
        int x;
        x = int'(v);
        case (op)
            OP_CLR: x = 0;
            OP_LD:  x = int'(d);
            OP_SL:  for (int i = 0; i < n; i++) x = (x * 2 + (rot ? x / 8 : int'(fill))) % 16;
            default: for (int i = 0; i < n; i++) x = x / 2 + 8 * (rot ? x % 2 : int'(fill));
        endcase
        return x[W-1:0];
    endfunction

    // Called at a negedge with the DUT idle or about to be
    task automatic run_cmd(input logic [1:0] op, input int cnt, input logic rot,
                           input logic fill, input logic [W-1:0] data);
        int cyc;
        int exp_exec;
        logic act;
        logic [W-1:0] exp_v;
        exp_v    = ref_apply(model, op, cnt, rot, fill, data);
        exp_exec = (op == OP_CLR || op == OP_LD) ? 1 : cnt;
        cmd_op   = op;
        cmd_cnt  = cnt[CW-1:0];
        cmd_rot  = rot;
        cmd_fill = fill;
        cmd_data = data;
        cmd_valid = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_wait", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            act = (cyc <= exp_exec);
            check("busy", 32'(busy), 32'd1);
            check("sr_se", 32'(sr_se), 32'(act ? op : 2'b00));
            check("sr_clr", 32'(sr_clr), 32'(act && op == OP_CLR));
            check("sr_par", 32'(sr_par), 32'((act && op == OP_LD) ? data : 4'h0));
            check("sr_right_in", 32'(sr_right_in),
                  32'((act && op == OP_SL) ? (rot ? sr_q[W-1] : fill) : 1'b0));
            check("sr_left_in", 32'(sr_left_in),
                  32'((act && op == OP_SR) ? (rot ? sr_q[0] : fill) : 1'b0));
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_exec + 2));
        check("done", 32'(done), 32'd1);
        check("result", 32'(result), 32'(exp_v));
        check("register", 32'(sr_q), 32'(exp_v));
        check("ready_at_done", 32'(cmd_ready), 32'd1);
        model = exp_v;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("result_hold", 32'(result), 32'(exp_v));
    endtask

    initial begin
        int cyc;
        int done_cnt;
        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_sr_clr", 32'(sr_clr), 32'd1);
            check("rst_sr_se", 32'(sr_se), 32'd0);
            check("rst_ready", 32'(cmd_ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd1);
            check("rst_done", 32'(done), 32'd0);
            check("rst_result", 32'(result), 32'd0);
        end
        @(posedge clk);
        #1 clr_n = 1'b1;
        @(negedge clk);
        check("init_sr_clr", 32'(sr_clr), 32'd1);
        check("init_sr_se", 32'(sr_se), 32'd0);
        check("init_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_sr_clr", 32'(sr_clr), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("init_register", 32'(sr_q), 32'd0);
        model = '0;

        // Directed commands
        run_cmd(OP_LD, 0, 1'b0, 1'b0, 4'b1011);
        run_cmd(OP_SL, 2, 1'b0, 1'b1, 4'h0);
        run_cmd(OP_LD, 5, 1'b0, 1'b0, 4'b1011);
        run_cmd(OP_SR, 3, 1'b0, 1'b0, 4'h0);
        run_cmd(OP_LD, 0, 1'b0, 1'b0, 4'b1011);
        run_cmd(OP_SR, 1, 1'b1, 1'b0, 4'h0);
        run_cmd(OP_LD, 0, 1'b0, 1'b0, 4'b1011);
        run_cmd(OP_SL, 4, 1'b1, 1'b0, 4'h0);
        run_cmd(OP_SL, 0, 1'b0, 1'b1, 4'h0);
        run_cmd(OP_SR, 0, 1'b1, 1'b1, 4'h0);
        run_cmd(OP_CLR, 3, 1'b0, 1'b1, 4'hF);
        run_cmd(OP_SR, 7, 1'b0, 1'b1, 4'h0);

        // Back-to-back: second command held valid while the first is busy
        cmd_op = OP_LD; cmd_cnt = '0; cmd_rot = 1'b0; cmd_fill = 1'b0; cmd_data = 4'b0101;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_op = OP_SR; cmd_cnt = 3'd1; cmd_fill = 1'b1; cmd_data = 4'h0;
        cyc = 1;
        while (!done && cyc < 20) begin
            check("b2b_not_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check("b2b_a_latency", 32'(cyc), 32'd3);
        check("b2b_a_result", 32'(result), 32'h5);
        check("b2b_ready_in_done", 32'(cmd_ready), 32'd1);
        model = 4'b0101;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_b_se", 32'(sr_se), 32'(OP_SR));
        check("b2b_b_left_in", 32'(sr_left_in), 32'd1);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_b_latency", 32'(cyc), 32'd3);
        check("b2b_b_result", 32'(result), 32'(ref_apply(model, OP_SR, 1, 1'b0, 1'b1, 4'h0)));
        model = ref_apply(model, OP_SR, 1, 1'b0, 1'b1, 4'h0);
        @(negedge clk);

        // Random commands
        for (int i = 0; i < 30; i++) begin
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom),
                    1'($urandom), 4'($urandom));
        end

        // Reset in the middle of a 5-cycle shift
        run_cmd(OP_LD, 0, 1'b0, 1'b0, 4'b1011);
        cmd_op = OP_SL; cmd_cnt = 3'd5; cmd_rot = 1'b0; cmd_fill = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_exec1_se", 32'(sr_se), 32'(OP_SL));
        @(negedge clk);
        check("abort_exec2_se", 32'(sr_se), 32'(OP_SL));
        #1 clr_n = 1'b0;
        #1;
        check("abort_sr_se", 32'(sr_se), 32'd0);
        check("abort_sr_clr", 32'(sr_clr), 32'd1);
        check("abort_ready", 32'(cmd_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 clr_n = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        if (done) done_cnt++;
        check("abort_init_clr", 32'(sr_clr), 32'd1);
        check("abort_init_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        if (done) done_cnt++;
        check("abort_idle_ready", 32'(cmd_ready), 32'd1);
        check("abort_register", 32'(sr_q), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        model = '0;
        run_cmd(OP_SL, 3, 1'b0, 1'b1, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
